ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 device-to-host receiver with a configurable-depth receive FIFO.
- Adds over the previous keyboard receiver: a framed receive FSM with stop-bit check, an idle watchdog, sticky error flags, a fill-level output, a first-word-fall-through pop handshake, and optional folding of E0/F0 prefix bytes into flag bits.
- Sits between the PS/2 pins and keyboard consumers (scan-code decoders, sound/display logic).

Parameters:
- FIFO_DEPTH, 8: entries; power of two, ≥2.
- SYNC_STAGES, 3: synchroniser flops on ps2_clk/ps2_data; ≥2.
- TIMEOUT_CYC, 100000: clk cycles with no ps2_clk falling edge before an in-progress frame is abandoned.
- DECODE, 1: 1 = fold E0/F0 prefixes into flags; 0 = raw bytes.

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-high reset
- ps2_clk  in  1  PS/2 clock pin, asynchronous
- ps2_data  in  1  PS/2 data pin, asynchronous
- rd_en  in  1  pop request; honoured only when valid=1
- data  out  OUT_W  FIFO head; OUT_W=10 if DECODE else 8; {brk,ext,code[7:0]} when DECODE=1
- valid  out  1  FIFO non-empty
- level  out  $clog2(FIFO_DEPTH)+1  current entry count
- overflow  out  1  sticky: a received entry was dropped because the FIFO was full
- frame_err  out  1  sticky: parity, stop-bit or timeout error
- err_clr  in  1  clears overflow and frame_err

Behaviour:
- Reset (clr=1, async):
  - FSM to IDLE; FIFO empty; prefix flags cleared.
  - data=0, valid=0, level=0, overflow=0, frame_err=0.
  - Synchroniser flops reset to 1 (bus idle), so release from reset produces no false edge.
  - Reset mid-frame discards the partial frame.
- Edge detect: fall = previous synced ps2_clk is 1 and current is 0. On a fall cycle, the synced ps2_data is the sampled bit.
- Frame FSM, advancing only on fall:
  - IDLE: bit 0 → DATA with bit counter=0. Bit 1 → stay IDLE, no error.
  - DATA: shift bits in LSB first; after 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if stop=1 and ^{byte,parity}=1 (odd parity), pulse byte_ok for one cycle. Otherwise set frame_err and discard the byte. Return to IDLE in both cases.
- Watchdog:
  - Counter clears on every fall and while in IDLE.
  - In a non-IDLE state, reaching TIMEOUT_CYC forces IDLE and sets frame_err.
- Decoder, acting on the byte_ok cycle:
  - DECODE=1:
    - 0xE0 sets ext, no push.
    - 0xF0 sets brk, no push.
    - Any other byte pushes {brk,ext,byte}, then clears ext and brk.
    - E0 E0 keeps ext=1.
  - DECODE=0: every accepted byte pushes, including E0/F0.
- Latency: byte_ok is registered in the cycle after the stop-bit fall. The push occurs on that byte_ok cycle. valid, data and level are updated exactly 2 clk cycles after the stop-bit fall cycle.
- FIFO:
  - Read/write pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty use the MSB compare; pointers wrap naturally.
  - pop = rd_en & valid.
  - push accepted if !full or pop in the same cycle. Push with pop while full: head removed, new entry written, level unchanged.
  - Push while full with no pop: entry dropped, overflow set.
  - rd_en while empty: ignored.
  - data = valid ? mem[rd_ptr] : 0, combinational (FWFT).
  - Simultaneous push and pop while empty: push happens; valid rises next cycle.
- Flags: err_clr clears both flags. A set event in the same cycle as err_clr wins, so the flag stays 1.

Decomposition:
- Package ps2_pkg:
  - PS2_EXT_PREFIX = 8'hE0, PS2_BREAK_PREFIX = 8'hF0.
  - Frame-FSM state encoding: IDLE, DATA, PARITY, STOP.
  - OUT_W derivation helper.
- Sub-module ps2_sync_fifo: parametrised FWFT FIFO with push/pop/full/empty/level.
- The top instantiates the FIFO and holds the synchroniser, FSM, watchdog and decoder.

Test Plan:
- Frame 0x1C (start 0, LSB first, parity 0, stop 1), DECODE=1 → 2 cycles after the stop fall: valid=1, data=0x01C, level=1. rd_en for 1 cycle → valid=0, data=0, level=0.
- Frames E0, F0, 75 → exactly one entry, data=0x375. Then frame 1C → data=0x01C (flags cleared). With DECODE=0, the same stimulus gives entries E0, F0, 75.
- Frame 0x1C with parity 1, then 0x1C with stop 0 → no push, frame_err=1. err_clr → frame_err=0. Assert err_clr in the same cycle as a bad stop → frame_err stays 1.
- FIFO_DEPTH=8, frames 0x01..0x09 with no reads → level=8, overflow=1. Reads return 0x01..0x08, then valid=0. With full FIFO, rd_en coincident with the push of 0x0A → level stays 8, tail=0x0A.
- Send 4 data bits, then hold ps2_clk high for TIMEOUT_CYC+2 cycles → frame_err=1, no push. Next frame 0x29 → data=0x029.
- Assert clr after 5 bits of a frame → all outputs 0. Release clr, send frame 0x5A → data=0x05A, level=1, frame_err=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, frame-FSM state type and output-width helper for the PS/2 receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    // Decoded entries carry {brk, ext} above the scan code.
    function automatic int unsigned out_width(input int unsigned decode);
        return (decode != 0) ? 10 : 8;
    endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers.
module ps2_sync_fifo #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the read port is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchroniser, framed receive FSM, watchdog,
// prefix decoder and a FWFT receive FIFO with sticky error flags.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH  = 8,
    parameter  int unsigned SYNC_STAGES = 3,
    parameter  int unsigned TIMEOUT_CYC = 100000,
    parameter  int unsigned DECODE      = 1,
    localparam int unsigned OUT_W       = out_width(DECODE),
    localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             rd_en,
    output logic [OUT_W-1:0] data,
    output logic             valid,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int unsigned      WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYC);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   dat_s;
    logic                   fall;

    ps2_state_t             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par;
    logic                   byte_ok;
    logic                   frame_good;
    logic                   stop_err;
    logic                   timeout;
    logic [WD_W-1:0]        wd_cnt;

    logic                   ext;
    logic                   brk;
    logic                   is_ext;
    logic                   is_brk;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [OUT_W-1:0]       wr_data;

    assign clk_s      = clk_sync[SYNC_STAGES-1];
    assign dat_s      = dat_sync[SYNC_STAGES-1];
    assign fall       = clk_prev & ~clk_s;
    assign frame_good = dat_s & (^{shreg, par});
    assign stop_err   = fall & (state == STOP) & ~frame_good;
    assign timeout    = (state != IDLE) && !fall && (wd_cnt == WD_LIMIT);

    // Pin synchronisers and edge history; idle-high reset avoids a false fall on release.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_s;
        end
    end

    // Watchdog: counts clk cycles between falls while a frame is in progress.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wd_cnt <= '0;
        end else if (fall || state == IDLE) begin
            wd_cnt <= '0;
        end else if (wd_cnt != WD_LIMIT) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Frame FSM: start, 8 data bits LSB first, odd parity, stop; byte_ok is a one-cycle pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            byte_ok <= 1'b0;
        end else begin
            byte_ok <= 1'b0;
            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s;
                        state <= STOP;
                    end
                    STOP: begin
                        byte_ok <= frame_good;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign is_ext = (DECODE != 0) && (shreg == PS2_EXT_PREFIX);
    assign is_brk = (DECODE != 0) && (shreg == PS2_BREAK_PREFIX);
    assign push   = byte_ok & ~is_ext & ~is_brk;
    assign pop    = rd_en & valid;

    // Prefix flags: accumulate E0/F0, drop both once a code byte is pushed.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_ok) begin
            if (is_ext) begin
                ext <= 1'b1;
            end else if (is_brk) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // FIFO entry format depends on decoding mode.
    always_comb begin
        wr_data = '0;
        if (DECODE != 0) wr_data = OUT_W'({brk, ext, shreg});
        else             wr_data = OUT_W'(shreg);
    end

    // Sticky error flags; a set event in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push & full & ~pop) overflow <= 1'b1;
            else if (err_clr)       overflow <= 1'b0;
            if (stop_err | timeout) frame_err <= 1'b1;
            else if (err_clr)       frame_err <= 1'b0;
        end
    end

    ps2_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign valid = ~empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: a decoding instance and a raw-byte instance share the PS/2 pins.
module tb_ps2_rx_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned TMO   = 200;
    localparam int unsigned HALF  = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic       ps2_clk;
    logic       ps2_data;
    logic       rd_en;
    logic       rd_en_raw;
    logic       err_clr;

    logic [9:0] data;
    logic       valid;
    logic [3:0] level;
    logic       overflow;
    logic       frame_err;

    logic [7:0] data_raw;
    logic       valid_raw;
    logic [3:0] level_raw;
    logic       overflow_raw;
    logic       frame_err_raw;

    int         vectors     = 0;
    int         miscompares = 0;
    int         lat;

    logic [9:0] exp_q[$];
    logic [7:0] raw_q[$];
    bit         m_ext;
    bit         m_brk;

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO),
        .DECODE      (1)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .valid     (valid),
        .level     (level),
        .overflow  (overflow),
        .frame_err (frame_err),
        .err_clr   (err_clr)
    );

    ps2_rx_fifo #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TMO),
        .DECODE      (0)
    ) dut_raw (
        .clk       (clk),
        .clr       (clr),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en_raw),
        .data      (data_raw),
        .valid     (valid_raw),
        .level     (level_raw),
        .overflow  (overflow_raw),
        .frame_err (frame_err_raw),
        .err_clr   (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    // One PS/2 bit: data set while clock is high, then a low half-period.
    // errc raises err_clr on the cycle the DUT sees this fall; pp pops on the resulting push cycle.
    task automatic ps2_bit(input logic b, input bit errc, input bit pp, output int l);
        logic [3:0] lvl0;
        ps2_data = b;
        wait_n(HALF);
        lvl0    = level;
        l       = 0;
        ps2_clk = 1'b0;
        for (int n = 1; n <= int'(HALF); n++) begin
            tick();
            if (n == int'(SYNC)) err_clr = errc;
            if (n == int'(SYNC) + 1) begin
                err_clr = 1'b0;
                if (pp) begin
                    if (exp_q.size() > 0) begin
                        check("coincident_pop_head", 32'(data), 32'(exp_q[0]));
                        void'(exp_q.pop_front());
                    end
                    rd_en = 1'b1;
                end
            end
            if (n == int'(SYNC) + 2) rd_en = 1'b0;
            if (l == 0 && level != lvl0) l = n;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit errc, input bit pp, output int l);
        int   dummy;
        logic p;
        p = bad_par ? ^b : ~^b;
        ps2_bit(1'b0, 1'b0, 1'b0, dummy);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, 1'b0, dummy);
        ps2_bit(p, 1'b0, 1'b0, dummy);
        ps2_bit(~bad_stop, errc, pp, l);
        ps2_data = 1'b1;
        wait_n(HALF);
    endtask

    // Expected-entry model for an accepted byte on both instances.
    task automatic model_good(input logic [7:0] b);
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_brk, m_ext, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        if (raw_q.size() < DEPTH) raw_q.push_back(b);
    endtask

    task automatic good(input logic [7:0] b);
        int l;
        send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, l);
        model_good(b);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        if (exp_q.size() > 0) begin
            check(tag, 32'(data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
    endtask

    task automatic pop_raw(input string tag);
        if (raw_q.size() > 0) begin
            check(tag, 32'(data_raw), 32'(raw_q[0]));
            void'(raw_q.pop_front());
        end
        rd_en_raw = 1'b1;
        tick();
        rd_en_raw = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        wait_n(3);
        clr = 1'b0;
        exp_q.delete();
        raw_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick();
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int dummy;
        clr       = 1'b1;
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        rd_en     = 1'b0;
        rd_en_raw = 1'b0;
        err_clr   = 1'b0;
        m_ext     = 1'b0;
        m_brk     = 1'b0;
        wait_n(3);

        // Reset state
        check("rst_data",      32'(data),          32'd0);
        check("rst_valid",     32'(valid),         32'd0);
        check("rst_level",     32'(level),         32'd0);
        check("rst_overflow",  32'(overflow),      32'd0);
        check("rst_frame_err", 32'(frame_err),     32'd0);
        check("rst_raw_valid", 32'(valid_raw),     32'd0);
        check("rst_raw_level", 32'(level_raw),     32'd0);
        check("rst_raw_flags", 32'({overflow_raw, frame_err_raw}), 32'd0);
        clr = 1'b0;
        tick();

        // Single frame, push latency and pop
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        model_good(8'h1C);
        check("push_latency", 32'(lat), 32'(SYNC + 2));
        check("f1c_data",  32'(data),  32'h01C);
        check("f1c_valid", 32'(valid), 32'd1);
        check("f1c_level", 32'(level), 32'd1);
        pop_check("f1c_pop");
        check("f1c_empty_valid", 32'(valid), 32'd0);
        check("f1c_empty_data",  32'(data),  32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_empty_level", 32'(level), 32'd0);

        // Prefix folding vs raw bytes
        do_reset();
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        check("e0f0_level", 32'(level), 32'd1);
        check("e0f0_data",  32'(data),  32'h375);
        check("raw_level",  32'(level_raw), 32'd3);
        pop_raw("raw_e0");
        pop_raw("raw_f0");
        pop_raw("raw_75");
        check("raw_drained", 32'(valid_raw), 32'd0);
        pop_check("e0f0_pop");
        good(8'h1C);
        check("flags_cleared", 32'(data), 32'h01C);
        pop_check("flags_cleared_pop");
        good(8'hE0);
        good(8'hE0);
        good(8'h12);
        check("e0e0_data", 32'(data), 32'h112);
        pop_check("e0e0_pop");

        // Frame errors and err_clr priority
        do_reset();
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, dummy);
        check("bad_par_err",   32'(frame_err), 32'd1);
        check("bad_par_level", 32'(level),     32'd0);
        pulse_err_clr();
        check("err_clr_1", 32'(frame_err), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0, dummy);
        check("bad_stop_err",   32'(frame_err), 32'd1);
        check("bad_stop_level", 32'(level),     32'd0);
        pulse_err_clr();
        check("err_clr_2", 32'(frame_err), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, dummy);
        check("set_beats_clr", 32'(frame_err), 32'd1);

        // Overflow, drain order, coincident push/pop when full
        do_reset();
        for (int v = 1; v <= 9; v++) good(8'(v));
        check("full_level",    32'(level),    32'd8);
        check("full_overflow", 32'(overflow), 32'd1);
        for (int v = 1; v <= 8; v++) pop_check("drain1");
        check("drain1_valid", 32'(valid), 32'd0);
        pulse_err_clr();
        check("ovf_cleared", 32'(overflow), 32'd0);
        for (int v = 8'h11; v <= 8'h18; v++) good(8'(v));
        check("refill_level", 32'(level), 32'd8);
        send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, dummy);
        model_good(8'h0A);
        check("coincident_level",    32'(level),    32'd8);
        check("coincident_overflow", 32'(overflow), 32'd0);
        for (int v = 1; v <= 8; v++) pop_check("drain2");
        check("drain2_valid", 32'(valid), 32'd0);

        // Watchdog abandons a stalled frame
        do_reset();
        ps2_bit(1'b0, 1'b0, 1'b0, dummy);
        ps2_bit(1'b1, 1'b0, 1'b0, dummy);
        ps2_bit(1'b0, 1'b0, 1'b0, dummy);
        ps2_bit(1'b1, 1'b0, 1'b0, dummy);
        ps2_bit(1'b1, 1'b0, 1'b0, dummy);
        ps2_data = 1'b1;
        wait_n(TMO + 20);
        check("timeout_err",   32'(frame_err), 32'd1);
        check("timeout_level", 32'(level),     32'd0);
        good(8'h29);
        check("after_timeout_data",  32'(data),  32'h029);
        check("after_timeout_level", 32'(level), 32'd1);

        // Reset mid-frame with a non-empty FIFO and frame_err set
        ps2_bit(1'b0, 1'b0, 1'b0, dummy);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0, 1'b0, dummy);
        clr = 1'b1;
        wait_n(2);
        check("midrst_data",      32'(data),      32'd0);
        check("midrst_valid",     32'(valid),     32'd0);
        check("midrst_level",     32'(level),     32'd0);
        check("midrst_overflow",  32'(overflow),  32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        clr = 1'b0;
        exp_q.delete();
        raw_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        tick();
        good(8'h5A);
        check("post_rst_data",  32'(data),      32'h05A);
        check("post_rst_level", 32'(level),     32'd1);
        check("post_rst_err",   32'(frame_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
